// File: rtl/char_physics_core.sv
// Platformer character physics: button sync, walk/charge/jump FSM,
// ballistic flight with wall/ceiling bounce and floor landing.
module char_physics_core #(
    parameter int PHY_WIDTH  = 10,
    parameter int X_MIN      = 10,
    parameter int X_MAX      = 90,
    parameter int Y_MIN      = 10,
    parameter int Y_MAX      = 90,
    parameter int CHAR_W     = 16,
    parameter int CHAR_H     = 16,
    parameter int INIT_X     = 42,
    parameter int INIT_Y     = 10,
    parameter int GRAVITY    = 1,
    parameter int MAX_VEL    = 25,
    parameter int WALK_STEP  = 1,
    parameter int JUMP_VX    = 2,
    parameter int JUMP_VY    = 5,
    parameter int MAX_CHARGE = 40,
    parameter int LEVELS     = 4,
    parameter int LAND_TICKS = 4
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    input  logic                        phys_tick,
    input  logic                        left_btn,
    input  logic                        right_btn,
    input  logic                        jump_btn,
    output logic signed [PHY_WIDTH:0]   pos_x,
    output logic signed [PHY_WIDTH:0]   pos_y,
    output logic signed [PHY_WIDTH:0]   vel_x,
    output logic signed [PHY_WIDTH:0]   vel_y,
    output logic                        face,
    output logic [2:0]                  state,
    output logic [1:0]                  charge_level,
    output logic                        on_ground,
    output logic                        bump
);

    localparam int W  = PHY_WIDTH + 1;
    localparam int CW = $clog2(MAX_CHARGE + 1);
    localparam int LW = $clog2(LAND_TICKS + 1);

    typedef logic signed [W-1:0] phy_t;
    typedef logic signed [W:0]   ext_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WALK   = 3'd1,
        S_CHARGE = 3'd2,
        S_AIR    = 3'd3,
        S_LAND   = 3'd4
    } state_t;

    localparam ext_t XLO  = ext_t'(X_MIN);
    localparam ext_t XHI  = ext_t'(X_MAX - CHAR_W);
    localparam ext_t YLO  = ext_t'(Y_MIN);
    localparam ext_t YHI  = ext_t'(Y_MAX - CHAR_H);
    localparam ext_t VMAX = ext_t'(MAX_VEL);
    localparam ext_t GRV  = ext_t'(GRAVITY);
    localparam ext_t STEP = ext_t'(WALK_STEP);

    function automatic ext_t sx(input phy_t v);
        return {v[W-1], v};
    endfunction

    function automatic phy_t clampv(input ext_t v);
        if (v > VMAX) begin
            return phy_t'(VMAX);
        end else if (v < -VMAX) begin
            return phy_t'(-VMAX);
        end
        return v[W-1:0];
    endfunction

    function automatic phy_t clampx(input ext_t v);
        if (v < XLO) begin
            return phy_t'(XLO);
        end else if (v > XHI) begin
            return phy_t'(XHI);
        end
        return v[W-1:0];
    endfunction

    state_t          r_state;
    state_t          n_state;
    phy_t            r_pos_x, r_pos_y, r_vel_x, r_vel_y;
    phy_t            n_pos_x, n_pos_y, n_vel_x, n_vel_y;
    logic            r_face, n_face;
    logic [CW-1:0]   r_charge_cnt, n_charge_cnt;
    logic [LW-1:0]   r_land_cnt, n_land_cnt;
    logic            r_bump, w_bump;

    logic            r_l_meta, r_l_sync;
    logic            r_r_meta, r_r_sync;
    logic            r_j_meta, r_j_sync, r_j_prev;
    logic            r_jump_pend;
    logic            w_jump_edge, w_pend;

    int              w_lvl_raw;
    logic [1:0]      w_level;
    ext_t            w_jvx, w_jvy;
    ext_t            w_cand_x, w_cand_y, w_vy_dec, w_walk_x;

    assign w_jump_edge = r_j_sync & ~r_j_prev;
    assign w_pend      = r_jump_pend | w_jump_edge;

    assign w_lvl_raw = int'(r_charge_cnt) * LEVELS / MAX_CHARGE;
    assign w_level   = (w_lvl_raw > LEVELS - 1) ? 2'(LEVELS - 1)
                                                : 2'(w_lvl_raw);

    assign w_jvx = ext_t'(JUMP_VX * (int'(w_level) + 1));
    assign w_jvy = ext_t'(JUMP_VY * (int'(w_level) + 1));

    assign w_cand_x = sx(r_pos_x) + sx(r_vel_x);
    assign w_cand_y = sx(r_pos_y) + sx(r_vel_y);
    assign w_vy_dec = sx(r_vel_y) - GRV;
    assign w_walk_x = r_r_sync ? sx(r_pos_x) + STEP : sx(r_pos_x) - STEP;

    always_comb begin
        n_state      = r_state;
        n_pos_x      = r_pos_x;
        n_pos_y      = r_pos_y;
        n_vel_x      = r_vel_x;
        n_vel_y      = r_vel_y;
        n_face       = r_face;
        n_charge_cnt = r_charge_cnt;
        n_land_cnt   = r_land_cnt;
        w_bump       = 1'b0;
        unique case (r_state)
            S_IDLE, S_WALK: begin
                if (w_pend) begin
                    n_state      = S_CHARGE;
                    n_charge_cnt = '0;
                end else if (r_l_sync ^ r_r_sync) begin
                    n_state = S_WALK;
                    n_face  = r_r_sync;
                    n_pos_x = clampx(w_walk_x);
                end else begin
                    n_state = S_IDLE;
                end
            end
            S_CHARGE: begin
                if (!r_j_sync || r_charge_cnt == CW'(MAX_CHARGE)) begin
                    n_state = S_AIR;
                    n_vel_x = clampv(r_face ? w_jvx : -w_jvx);
                    n_vel_y = clampv(w_jvy);
                end else begin
                    n_charge_cnt = r_charge_cnt + 1'b1;
                end
            end
            S_AIR: begin
                n_pos_x = w_cand_x[W-1:0];
                n_pos_y = w_cand_y[W-1:0];
                n_vel_y = clampv(w_vy_dec);
                if (w_cand_x < XLO || w_cand_x > XHI) begin
                    n_pos_x = clampx(w_cand_x);
                    n_vel_x = clampv(-sx(r_vel_x));
                    n_face  = ~r_face;
                    w_bump  = 1'b1;
                end
                if (w_cand_y > YHI) begin
                    n_pos_y = phy_t'(YHI);
                    n_vel_y = '0;
                    w_bump  = 1'b1;
                end
                // Floor wins over velocity; wall position fix above is kept
                if (w_cand_y <= YLO) begin
                    n_pos_y    = phy_t'(YLO);
                    n_vel_x    = '0;
                    n_vel_y    = '0;
                    n_state    = S_LAND;
                    n_land_cnt = '0;
                end
            end
            S_LAND: begin
                if (r_land_cnt == LW'(LAND_TICKS - 1)) begin
                    n_state = S_IDLE;
                end else begin
                    n_land_cnt = r_land_cnt + 1'b1;
                end
            end
            default: begin
                n_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_l_meta     <= 1'b0;
            r_l_sync     <= 1'b0;
            r_r_meta     <= 1'b0;
            r_r_sync     <= 1'b0;
            r_j_meta     <= 1'b0;
            r_j_sync     <= 1'b0;
            r_j_prev     <= 1'b0;
            r_jump_pend  <= 1'b0;
            r_bump       <= 1'b0;
            r_state      <= S_IDLE;
            r_pos_x      <= phy_t'(INIT_X);
            r_pos_y      <= phy_t'(INIT_Y);
            r_vel_x      <= '0;
            r_vel_y      <= '0;
            r_face       <= 1'b1;
            r_charge_cnt <= '0;
            r_land_cnt   <= '0;
        end else begin
            r_l_meta    <= left_btn;
            r_l_sync    <= r_l_meta;
            r_r_meta    <= right_btn;
            r_r_sync    <= r_r_meta;
            r_j_meta    <= jump_btn;
            r_j_sync    <= r_j_meta;
            r_j_prev    <= r_j_sync;
            // Edge is consumed by the next tick whatever state it finds
            r_jump_pend <= phys_tick ? 1'b0 : w_pend;
            r_bump      <= phys_tick & w_bump;
            if (phys_tick) begin
                r_state      <= n_state;
                r_pos_x      <= n_pos_x;
                r_pos_y      <= n_pos_y;
                r_vel_x      <= n_vel_x;
                r_vel_y      <= n_vel_y;
                r_face       <= n_face;
                r_charge_cnt <= n_charge_cnt;
                r_land_cnt   <= n_land_cnt;
            end
        end
    end

    assign pos_x        = r_pos_x;
    assign pos_y        = r_pos_y;
    assign vel_x        = r_vel_x;
    assign vel_y        = r_vel_y;
    assign face         = r_face;
    assign state        = r_state;
    assign charge_level = w_level;
    assign on_ground    = (r_state != S_AIR);
    assign bump         = r_bump;

endmodule

// File: tb/tb_char_physics_core.sv
// Directed bench for char_physics_core: walk table plus jump,
// wall/ceiling, landing, reset and tick-gating sequences.
module tb_char_physics_core;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic phys_tick = 1'b0;
    logic left_btn = 1'b0;
    logic right_btn = 1'b0;
    logic jump_btn = 1'b0;
    logic signed [10:0] pos_x, pos_y, vel_x, vel_y;
    logic face, on_ground, bump;
    logic [2:0] state;
    logic [1:0] charge_level;

    char_physics_core dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .phys_tick    (phys_tick),
        .left_btn     (left_btn),
        .right_btn    (right_btn),
        .jump_btn     (jump_btn),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .vel_x        (vel_x),
        .vel_y        (vel_y),
        .face         (face),
        .state        (state),
        .charge_level (charge_level),
        .on_ground    (on_ground),
        .bump         (bump)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic bump_seen;
    logic saw_land;
    int guard;

    typedef struct {
        logic rst;
        logic l;
        logic r;
        logic j;
        int   n;
        int   st;
        int   x;
        int   fc;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_tick();
        repeat (3) @(negedge sys_clk);
        phys_tick = 1'b1;
        @(posedge sys_clk);
        #1;
        phys_tick = 1'b0;
        if (bump === 1'b1) bump_seen = 1'b1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic do_reset();
        left_btn = 1'b0;
        right_btn = 1'b0;
        jump_btn = 1'b0;
        @(negedge sys_clk);
        sys_rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1,  0, 42, 1};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1,  1, 43, 1};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 5,  1, 48, 1};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 3,  1, 45, 0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 2,  0, 45, 0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1,  0, 45, 0};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 40, 1, 10, 0};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 40, 1, 74, 1};
        tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 3,  0, 74, 1};
        bump_seen = 1'b0;

        // Reset state
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("rst_state", int'(state), 0);
        chk("rst_x", int'(pos_x), 42);
        chk("rst_y", int'(pos_y), 10);
        chk("rst_vx", int'(vel_x), 0);
        chk("rst_vy", int'(vel_y), 0);
        chk("rst_face", int'(face), 1);
        chk("rst_gnd", int'(on_ground), 1);
        chk("rst_bump", int'(bump), 0);
        chk("rst_lvl", int'(charge_level), 0);

        // Walking table
        for (int k = 0; k < 9; k++) begin
            if (tbl[k].rst) do_reset();
            left_btn = tbl[k].l;
            right_btn = tbl[k].r;
            jump_btn = tbl[k].j;
            bump_seen = 1'b0;
            ticks(tbl[k].n);
            chk($sformatf("walk%0d_state", k), int'(state), tbl[k].st);
            chk($sformatf("walk%0d_x", k), int'(pos_x), tbl[k].x);
            chk($sformatf("walk%0d_y", k), int'(pos_y), 10);
            chk($sformatf("walk%0d_face", k), int'(face), tbl[k].fc);
            chk($sformatf("walk%0d_bump", k), int'(bump_seen), 0);
            chk($sformatf("walk%0d_vx", k), int'(vel_x), 0);
        end

        // Tap jump: level 0 launch, 11 air ticks, 4 land ticks
        do_reset();
        jump_btn = 1'b1;
        do_tick();
        chk("tap_charge", int'(state), 2);
        jump_btn = 1'b0;
        do_tick();
        chk("tap_air", int'(state), 3);
        chk("tap_vx", int'(vel_x), 2);
        chk("tap_vy", int'(vel_y), 5);
        chk("tap_x0", int'(pos_x), 42);
        chk("tap_y0", int'(pos_y), 10);
        chk("tap_gnd", int'(on_ground), 0);
        ticks(10);
        chk("tap10_state", int'(state), 3);
        chk("tap10_x", int'(pos_x), 62);
        chk("tap10_y", int'(pos_y), 15);
        chk("tap10_vy", int'(vel_y), -5);
        do_tick();
        chk("tap_land", int'(state), 4);
        chk("tap_land_x", int'(pos_x), 64);
        chk("tap_land_y", int'(pos_y), 10);
        chk("tap_land_vx", int'(vel_x), 0);
        chk("tap_land_vy", int'(vel_y), 0);
        chk("tap_land_gnd", int'(on_ground), 1);
        ticks(3);
        chk("tap_land3", int'(state), 4);
        do_tick();
        chk("tap_idle", int'(state), 0);

        // Full charge right, ceiling then right wall, held through landing
        do_reset();
        jump_btn = 1'b1;
        do_tick();
        chk("full_charge", int'(state), 2);
        for (int i = 1; i <= 40; i++) begin
            do_tick();
            if (i == 10) chk("lvl_at10", int'(charge_level), 1);
            if (i == 29) chk("lvl_at29", int'(charge_level), 2);
        end
        chk("full_still_charge", int'(state), 2);
        chk("full_lvl", int'(charge_level), 3);
        do_tick();
        chk("full_air", int'(state), 3);
        chk("full_vx", int'(vel_x), 8);
        chk("full_vy", int'(vel_y), 20);
        ticks(3);
        chk("pre_ceil_y", int'(pos_y), 67);
        chk("pre_ceil_bump", int'(bump), 0);
        do_tick();
        chk("ceil_y", int'(pos_y), 74);
        chk("ceil_vy", int'(vel_y), 0);
        chk("ceil_bump", int'(bump), 1);
        chk("ceil_x", int'(pos_x), 74);
        chk("ceil_vx", int'(vel_x), 8);
        @(posedge sys_clk);
        #1;
        chk("ceil_bump_pulse", int'(bump), 0);
        do_tick();
        chk("wall_x", int'(pos_x), 74);
        chk("wall_vx", int'(vel_x), -8);
        chk("wall_face", int'(face), 0);
        chk("wall_bump", int'(bump), 1);
        chk("wall_vy", int'(vel_y), -1);
        @(posedge sys_clk);
        #1;
        chk("wall_bump_pulse", int'(bump), 0);
        saw_land = 1'b0;
        guard = 0;
        while (state != 3'd0 && guard < 200) begin
            do_tick();
            if (state == 3'd4) saw_land = 1'b1;
            guard++;
        end
        chk("fall_bound", int'(guard < 200), 1);
        chk("fall_saw_land", int'(saw_land), 1);
        chk("fall_y", int'(pos_y), 10);
        ticks(5);
        chk("held_no_charge", int'(state), 0);

        // Full charge facing left
        do_reset();
        left_btn = 1'b1;
        do_tick();
        chk("left_face", int'(face), 0);
        left_btn = 1'b0;
        jump_btn = 1'b1;
        ticks(42);
        chk("left_air", int'(state), 3);
        chk("left_vx", int'(vel_x), -8);
        chk("left_vy", int'(vel_y), 20);

        // Asynchronous reset in flight
        do_reset();
        jump_btn = 1'b1;
        do_tick();
        jump_btn = 1'b0;
        ticks(4);
        chk("mid_air", int'(state), 3);
        @(negedge sys_clk);
        #2;
        sys_rst = 1'b1;
        #1;
        chk("arst_state", int'(state), 0);
        chk("arst_x", int'(pos_x), 42);
        chk("arst_y", int'(pos_y), 10);
        chk("arst_vx", int'(vel_x), 0);
        chk("arst_vy", int'(vel_y), 0);
        chk("arst_face", int'(face), 1);
        chk("arst_gnd", int'(on_ground), 1);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        do_tick();
        chk("arst_rel_state", int'(state), 0);
        chk("arst_rel_x", int'(pos_x), 42);

        // No ticks for 100 cycles while buttons toggle
        do_reset();
        right_btn = 1'b1;
        ticks(3);
        chk("gate_pre_x", int'(pos_x), 45);
        for (int i = 0; i < 100; i++) begin
            @(negedge sys_clk);
            left_btn = (i % 3 == 0) && (i < 98);
            right_btn = (i % 5 == 1) && (i < 98);
            jump_btn = (i < 96) ? ((i / 4) % 2 == 1) : (i >= 98);
        end
        chk("gate_state", int'(state), 1);
        chk("gate_x", int'(pos_x), 45);
        chk("gate_y", int'(pos_y), 10);
        chk("gate_vx", int'(vel_x), 0);
        do_tick();
        chk("gate_pend_charge", int'(state), 2);
        chk("gate_pend_x", int'(pos_x), 45);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/char_physics_core.md
CHAR_PHYSICS_CORE -- requirements
Module: char_physics_core

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- PHY_WIDTH, 10, pos/vel are signed PHY_WIDTH+1 bits
- X_MIN, 10, left wall (min char left edge)
- X_MAX, 90, right wall (max char right edge)
- Y_MIN, 10, floor (min char bottom edge)
- Y_MAX, 90, ceiling (max char top edge)
- CHAR_W, 16, char width
- CHAR_H, 16, char height
- INIT_X, 42, reset pos_x
- INIT_Y, 10, reset pos_y
- GRAVITY, 1, vel_y decrement per AIR tick
- MAX_VEL, 25, vel magnitude clamp
- WALK_STEP, 1, pixels per WALK tick
- JUMP_VX, 2, vel_x per charge level
- JUMP_VY, 5, vel_y per charge level
- MAX_CHARGE, 40, charge ticks for auto-launch; multiple of LEVELS
- LEVELS, 4, number of jump strength levels
- LAND_TICKS, 4, LAND dwell in ticks
REQ-002 Ports (name, direction, width, meaning), one per line:
- sys_clk  in  1  single clock
- sys_rst  in  1  asynchronous, active-high reset
- phys_tick  in  1  one-cycle physics step enable
- left_btn / right_btn / jump_btn  in  1 each  raw buttons, asynchronous to sys_clk
- pos_x, pos_y  out  PHY_WIDTH+1 signed  char bottom-left corner
- vel_x, vel_y  out  PHY_WIDTH+1 signed  velocity, +x right, +y up
- face  out  1  0 = left, 1 = right
- state  out  3  IDLE=0, WALK=1, CHARGE=2, AIR=3, LAND=4
- charge_level  out  2  0..LEVELS-1 (level minus 1)
- on_ground  out  1  high in IDLE/WALK/CHARGE/LAND
- bump  out  1  one-sys_clk pulse on wall/ceiling hit in AIR

Function
REQ-003 Buttons SHALL pass a 2-FF synchronizer; jump rising edge SHALL be detected on synchronized samples and held pending until the next phys_tick.
REQ-004 All state, pos, vel, face and charge registers SHALL update only on sys_clk edges where phys_tick=1.
REQ-005 IDLE/WALK: a pending jump edge -> CHARGE (priority over walking); otherwise exactly one of left/right held -> WALK, moving WALK_STEP that direction and setting face; neither or both held -> IDLE, no motion.
REQ-006 WALK SHALL clamp pos_x to [X_MIN, X_MAX-CHAR_W] with no bump.
REQ-007 CHARGE: charge_cnt SHALL clear on entry, increment once per tick, saturate at MAX_CHARGE; charge_level = min(charge_cnt*LEVELS/MAX_CHARGE, LEVELS-1).
REQ-008 Launch on the tick where jump is released or charge_cnt = MAX_CHARGE: vel_x = JUMP_VX*(level+1)*(face?+1:-1), vel_y = JUMP_VY*(level+1), state -> AIR, pos unchanged that tick.
REQ-009 AIR tick: candidate pos = pos + vel (current vel); then vel_y = max(vel_y-GRAVITY, -MAX_VEL); all buttons ignored.
REQ-010 Side wall in AIR: candidate beyond wall -> pos_x = that wall limit, vel_x negated, face toggled, bump=1.
REQ-011 Ceiling: candidate pos_y+CHAR_H > Y_MAX -> pos_y = Y_MAX-CHAR_H, vel_y = 0, bump=1.
REQ-012 Floor: candidate pos_y <= Y_MIN -> pos_y = Y_MIN, vel_x = vel_y = 0, state -> LAND; pos_x still updated/wall-checked that tick.
REQ-013 Simultaneous wall and floor in one tick: both corrections applied, bump=1, state -> LAND.
REQ-014 LAND: stays LAND_TICKS ticks, then IDLE; jump held through landing SHALL NOT charge until a new rising edge.
REQ-015 Sums SHALL use PHY_WIDTH+2-bit intermediates; vel clamped to ±MAX_VEL before register write.

Reset
REQ-016 sys_rst high SHALL immediately force state=IDLE, pos=(INIT_X, INIT_Y), vel=0, face=1, charge_cnt=0, charge_level=0, bump=0, on_ground=1, synchronizers cleared, including mid-flight.

Verification
REQ-017 Jump tapped one tick from (42,10), face=1 -> launch vel=(2,5); 11th AIR tick lands at (64,10), state LAND, then IDLE after 4 ticks.
REQ-018 Jump held 45 ticks -> auto-launch at charge_cnt=40, charge_level=3, vel=(8,20) face right or (-8,20) face left.
REQ-019 Right held 40 ticks from x=42 -> pos_x saturates at 74, state WALK, bump never asserted; both buttons held -> IDLE, no motion.
REQ-020 Full-charge jump facing right -> hits right wall: pos_x=74, vel_x=-8, face=0, single-cycle bump; ceiling hit clamps pos_y=74, vel_y=0.
REQ-021 sys_rst asserted mid-AIR between clock edges -> outputs at reset values before next sys_clk edge; release -> IDLE at (42,10).
REQ-022 phys_tick held low 100 cycles with buttons toggling -> pos/vel/state unchanged; pending jump edge honored on next tick.
